button_pulse_gen: RTL

BUTTON_PULSE_GEN -- requirements
Module: button_pulse_gen

---
 rtl/button_pulse_gen.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/button_pulse_gen.sv
// rtl/button_pulse_gen.sv - debounced push-button to single-cycle enable pulse, optional auto-repeat (AUTO_REPEAT_EN)
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic en_out,
    output logic btn_level,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // Out-of-range parameters are rejected at elaboration time.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_DELAY < 2 || REPEAT_DELAY > 65535 ||
        REPEAT_PERIOD < 2 || REPEAT_PERIOD > 65535) begin : g_param_range
        $error("button_pulse_gen: parameter out of range 2..65535");
    end

    logic        sync_meta;
    logic        sync_q;
    state_t      state;
    state_t      state_next;
    logic [15:0] db_cnt;
    logic [15:0] db_cnt_next;
    logic        press_pulse;
    logic        en_next;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(negedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= btn_in;
            sync_q    <= sync_meta;
        end
    end

    // FSM state, debounce counter and registered enable pulse.
    always_ff @(negedge clk) begin
        if (rst) begin
            state  <= IDLE;
            db_cnt <= 16'd0;
            en_out <= 1'b0;
        end else begin
            state  <= state_next;
            db_cnt <= db_cnt_next;
            en_out <= en_next;
        end
    end

    // Debounce qualification: next state, counter and press pulse request.
    always_comb begin
        state_next  = state;
        db_cnt_next = db_cnt;
        press_pulse = 1'b0;
        case (state)
            IDLE: begin
                db_cnt_next = 16'd0;
                if (sync_q) begin
                    state_next  = PRESS_WAIT;
                    db_cnt_next = 16'd1;
                end
            end
            PRESS_WAIT: begin
                if (!sync_q) begin
                    state_next  = IDLE;
                    db_cnt_next = 16'd0;
                end else if (db_cnt == DB_LAST) begin
                    state_next  = HELD;
                    db_cnt_next = 16'd0;
                    press_pulse = 1'b1;
                end else if (db_cnt != 16'hFFFF) begin
                    db_cnt_next = db_cnt + 16'd1;
                end
            end
            HELD: begin
                db_cnt_next = 16'd0;
                if (!sync_q) begin
                    state_next  = RELEASE_WAIT;
                    db_cnt_next = 16'd1;
                end
            end
            RELEASE_WAIT: begin
                if (sync_q) begin
                    // Release glitch: back to HELD without a new pulse.
                    state_next  = HELD;
                    db_cnt_next = 16'd0;
                end else if (db_cnt == DB_LAST) begin
                    state_next  = IDLE;
                    db_cnt_next = 16'd0;
                end else if (db_cnt != 16'hFFFF) begin
                    db_cnt_next = db_cnt + 16'd1;
                end
            end
            default: begin
                state_next  = IDLE;
                db_cnt_next = 16'd0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [15:0] RD_LAST = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RP_LAST = 16'(REPEAT_PERIOD - 1);

    logic [15:0] rpt_cnt;
    logic [15:0] rpt_cnt_next;
    logic        rpt_phase;
    logic        rpt_phase_next;
    logic        rpt_pulse;

    // Repeat counter and phase (0 = initial delay, 1 = periodic repeats).
    always_ff @(negedge clk) begin
        if (rst) begin
            rpt_cnt   <= 16'd0;
            rpt_phase <= 1'b0;
        end else begin
            rpt_cnt   <= rpt_cnt_next;
            rpt_phase <= rpt_phase_next;
        end
    end

    // Repeat timing: runs only while HELD persists, frozen during release qualification.
    always_comb begin
        rpt_cnt_next   = rpt_cnt;
        rpt_phase_next = rpt_phase;
        rpt_pulse      = 1'b0;
        if (press_pulse || state_next == IDLE) begin
            rpt_cnt_next   = 16'd0;
            rpt_phase_next = 1'b0;
        end else if (state == HELD && sync_q) begin
            if (!rpt_phase) begin
                if (rpt_cnt == RD_LAST) begin
                    rpt_pulse      = 1'b1;
                    rpt_cnt_next   = 16'd0;
                    rpt_phase_next = 1'b1;
                end else begin
                    rpt_cnt_next = rpt_cnt + 16'd1;
                end
            end else begin
                if (rpt_cnt == RP_LAST) begin
                    rpt_pulse    = 1'b1;
                    rpt_cnt_next = 16'd0;
                end else begin
                    rpt_cnt_next = rpt_cnt + 16'd1;
                end
            end
        end
    end

    assign en_next = press_pulse | rpt_pulse;
`else
    assign en_next = press_pulse;
`endif

    assign btn_level = (state == HELD) || (state == RELEASE_WAIT);
    assign busy      = (state == PRESS_WAIT) || (state == RELEASE_WAIT);

endmodule
